// File: rtl/n64_vdemux.sv
// N64 VI bus de-multiplexer: turns the nDSYNC-framed 4-cycle pixel quad on D_i
// into a registered {sync,R,G,B} word with a one-cycle valid strobe.
module n64_vdemux #(
  parameter int color_width = 7,
  parameter bit blur_fix_en = 1'b1
) (
  input  logic                         nCLK,
  input  logic                         RST,
  input  logic                         nDSYNC,
  input  logic [color_width-1:0]       D_i,
  input  logic [4:0]                   vinfo_i,
  input  logic                         deblur_i,
  output logic [3:0]                   Sync_pre,
  output logic [3:0]                   Sync_cur,
  output logic [3+3*color_width:0]     vdata_r_o,
  output logic                         vdata_valid_o
);

  localparam int VW = 4 + 3 * color_width;

  logic [1:0] data_cnt;
  logic       n64_480i;
  logic       blurry_pixel_pos;
  logic       unused_vmode;
  logic       hold;

  assign data_cnt         = vinfo_i[4:3];
  assign n64_480i         = vinfo_i[2];
  assign unused_vmode     = vinfo_i[1];
  assign blurry_pixel_pos = vinfo_i[0];

  // A 240p blurry pixel refreshes only the sync field; colour repeats the last good pixel.
  assign hold = blur_fix_en & deblur_i & ~n64_480i & blurry_pixel_pos;

  logic [3:0]             sync_pre_q, sync_pre_d;
  logic [3:0]             sync_cur_q, sync_cur_d;
  logic [color_width-1:0] r_q, r_d;
  logic [color_width-1:0] g_q, g_d;
  logic                   pixel_ok_q, pixel_ok_d;
  logic [VW-1:0]          vdata_q, vdata_d;
  logic                   valid_q, valid_d;

  always_comb begin
    sync_pre_d = sync_pre_q;
    sync_cur_d = sync_cur_q;
    r_d        = r_q;
    g_d        = g_q;
    pixel_ok_d = pixel_ok_q;
    vdata_d    = vdata_q;
    valid_d    = 1'b0;

    if (!nDSYNC) begin
      // A sync cycle always restarts the quad, even if B was due.
      sync_pre_d = sync_cur_q;
      sync_cur_d = D_i[3:0];
      pixel_ok_d = 1'b1;
    end else begin
      case (data_cnt)
        2'b01: r_d = D_i;
        2'b10: g_d = D_i;
        2'b11: begin
          if (pixel_ok_q) begin
            pixel_ok_d          = 1'b0;
            valid_d             = 1'b1;
            vdata_d[VW-1:VW-4]  = sync_cur_q;
            if (!hold) begin
              vdata_d[VW-5:0] = {r_q, g_q, D_i};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      sync_pre_q <= 4'hF;
      sync_cur_q <= 4'hF;
      r_q        <= '0;
      g_q        <= '0;
      pixel_ok_q <= 1'b0;
      vdata_q    <= {4'hF, {(3*color_width){1'b0}}};
      valid_q    <= 1'b0;
    end else begin
      sync_pre_q <= sync_pre_d;
      sync_cur_q <= sync_cur_d;
      r_q        <= r_d;
      g_q        <= g_d;
      pixel_ok_q <= pixel_ok_d;
      vdata_q    <= vdata_d;
      valid_q    <= valid_d;
    end
  end

  assign Sync_pre      = sync_pre_q;
  assign Sync_cur      = sync_cur_q;
  assign vdata_r_o     = vdata_q;
  assign vdata_valid_o = valid_q;

endmodule

// File: tb/tb_n64_vdemux.sv
// Scoreboard bench for n64_vdemux: stimulus pushes expected pixel words, a
// monitor pops one per valid strobe; sync nibbles and reset values checked directly.
module tb_n64_vdemux;

  logic        nCLK;
  logic        RST;
  logic        nDSYNC;
  logic [6:0]  D_i;
  logic [4:0]  vinfo_i;
  logic        deblur_i;
  logic [3:0]  Sync_pre;
  logic [3:0]  Sync_cur;
  logic [24:0] vdata_r_o;
  logic        vdata_valid_o;

  int checks   = 0;
  int failures = 0;
  logic [24:0] exp_q[$];

  n64_vdemux #(.color_width(7), .blur_fix_en(1'b1)) dut (
    .nCLK(nCLK), .RST(RST), .nDSYNC(nDSYNC), .D_i(D_i), .vinfo_i(vinfo_i),
    .deblur_i(deblur_i), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
    .vdata_r_o(vdata_r_o), .vdata_valid_o(vdata_valid_o)
  );

  initial nCLK = 1'b1;
  always #5 nCLK = ~nCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h t=%0t", name, act, $time);
    end
  endtask

  // Monitor: outputs change on negedge, so sample them on posedge.
  always @(posedge nCLK) begin
    if (vdata_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%h required=no_strobe t=%0t", vdata_r_o, $time);
      end else begin
        chk("pixel_word", {7'd0, vdata_r_o}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input logic nd, input logic [6:0] d, input logic [1:0] cnt,
                     input logic i480, input logic blur, input logic db);
    @(posedge nCLK);
    nDSYNC   = nd;
    D_i      = d;
    vinfo_i  = {cnt, i480, 1'b0, blur};
    deblur_i = db;
  endtask

  task automatic quad(input logic [6:0] s, input logic [6:0] r, input logic [6:0] g,
                      input logic [6:0] b, input logic i480, input logic blur,
                      input logic db, input logic push, input logic [24:0] exp_word);
    cyc(1'b0, s, 2'b00, i480, blur, db);
    cyc(1'b1, r, 2'b01, i480, blur, db);
    cyc(1'b1, g, 2'b10, i480, blur, db);
    if (push) exp_q.push_back(exp_word);
    cyc(1'b1, b, 2'b11, i480, blur, db);
  endtask

  // Wait for the edge that samples the last driven cycle, then look.
  task automatic after_edge();
    @(negedge nCLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sync_pre"}, {28'd0, Sync_pre}, 32'hF);
    chk({tag, "_sync_cur"}, {28'd0, Sync_cur}, 32'hF);
    chk({tag, "_vdata"}, {7'd0, vdata_r_o}, {7'd0, 4'hF, 21'h0});
    chk({tag, "_valid"}, {31'd0, vdata_valid_o}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; nDSYNC = 1'b1; D_i = '0; vinfo_i = '0; deblur_i = 1'b0;

    // Reset held for 3 cycles with the bus toggling.
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 7'h2A ^ 7'(i), 2'(i + 1), 1'b0, 1'b1, 1'b1);
      after_edge();
      chk_reset_vals("reset_hold");
    end
    cyc(1'b1, 7'h15, 2'b11, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;  // a B slot straight after release must not emit
    cyc(1'b1, 7'h16, 2'b00, 1'b1, 1'b0, 1'b0);

    // Normal 480i quad; deblur requested but 480i blocks it.
    quad(7'h0B, 7'h12, 7'h34, 7'h56, 1'b1, 1'b1, 1'b1, 1'b1, {4'hB, 7'h12, 7'h34, 7'h56});
    after_edge();
    chk("quad480_sync_pre", {28'd0, Sync_pre}, 32'hF);
    chk("quad480_sync_cur", {28'd0, Sync_cur}, 32'hB);
    chk("quad480_valid_now", {31'd0, vdata_valid_o}, 32'd1);
    cyc(1'b1, 7'h00, 2'b00, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("quad480_valid_drop", {31'd0, vdata_valid_o}, 32'd0);

    // 240p: good pixel A, then blurry B held, then blurry with deblur off.
    quad(7'h05, 7'h01, 7'h02, 7'h03, 1'b0, 1'b0, 1'b1, 1'b1, {4'h5, 7'h01, 7'h02, 7'h03});
    quad(7'h0A, 7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b1, 1'b1, 1'b1, {4'hA, 7'h01, 7'h02, 7'h03});
    quad(7'h0C, 7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b1, 1'b0, 1'b1, {4'hC, 7'h7F, 7'h7F, 7'h7F});
    after_edge();
    chk("deblur_sync_pre", {28'd0, Sync_pre}, 32'hA);

    // Short quad: sync arrives in the B slot.
    cyc(1'b0, 7'h03, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h11, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h22, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'h06, 2'b11, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("short_sync_pre", {28'd0, Sync_pre}, 32'h3);
    chk("short_sync_cur", {28'd0, Sync_cur}, 32'h6);
    chk("short_vdata_held", {7'd0, vdata_r_o}, {7'd0, 4'hC, 7'h7F, 7'h7F, 7'h7F});
    cyc(1'b1, 7'h21, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h22, 2'b10, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({4'h6, 7'h21, 7'h22, 7'h23});
    cyc(1'b1, 7'h23, 2'b11, 1'b0, 1'b0, 1'b0);

    // Overrun: four more data cycles with no nDSYNC.
    cyc(1'b1, 7'h40, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h41, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h42, 2'b10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7'h43, 2'b11, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("overrun_vdata_held", {7'd0, vdata_r_o}, {7'd0, 4'h6, 7'h21, 7'h22, 7'h23});

    // Reset pulsed during the G cycle, asynchronous to nCLK.
    cyc(1'b0, 7'h09, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 7'h55, 2'b01, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 7'h66, 2'b10, 1'b1, 1'b0, 1'b0);
    #2 RST = 1'b1;
    #1 chk_reset_vals("midreset_async");
    after_edge();
    chk_reset_vals("midreset_held");
    cyc(1'b1, 7'h33, 2'b11, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;  // pixel_ok was cleared, so this B slot must stay silent
    after_edge();
    chk("midreset_no_b", {7'd0, vdata_r_o}, {7'd0, 4'hF, 21'h0});
    quad(7'h0E, 7'h60, 7'h61, 7'h62, 1'b1, 1'b0, 1'b0, 1'b1, {4'hE, 7'h60, 7'h61, 7'h62});
    after_edge();
    chk("midreset_sync_pre", {28'd0, Sync_pre}, 32'hF);
    chk("midreset_sync_cur", {28'd0, Sync_cur}, 32'hE);

    // Drain: every expected word must have been consumed by the monitor.
    for (int i = 0; i < 4; i++) cyc(1'b1, 7'h00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge nCLK);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
